// File: rtl/alu_shift_sequencer.sv
// Breaks a multi-bit shift request into single-bit ALU shift steps, accumulating alu_otp each cycle.
// Optional ZERO_EARLY_EXIT_EN: finish early once the ALU reports a zero result.
`timescale 1ns/1ps
module alu_shift_sequencer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SHW       = 5,
  parameter logic [3:0]  SHIFT_GRP = 4'b0010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [5:0]       alu_alufn,
  input  logic [WIDTH-1:0] alu_otp,
  input  logic             alu_zero
);

  localparam logic [5:0] ALUFN_PASS = 6'b000010;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             zero_exit;

`ifdef ZERO_EARLY_EXIT_EN
  assign zero_exit = alu_zero;
`else
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;
  assign zero_exit       = 1'b0;
`endif

  assign alu_a = acc_q;

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          acc_d     = src;
          illegal_d = (op == OP_ILLEGAL);
          if ((op == OP_ILLEGAL) || (shamt == '0)) begin
            result_d = src;
            state_d  = DONE;
          end else begin
            cnt_d   = shamt;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = alu_otp;
        cnt_d = cnt_q - SHW'(1);
        if (zero_exit) begin
          result_d = '0;
          state_d  = DONE;
        end else if (cnt_q == SHW'(1)) begin
          result_d = alu_otp;
          state_d  = DONE;
        end
      end
      DONE: begin
        illegal_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      alu_b     <= '0;
      alu_alufn <= ALUFN_PASS;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      result    <= result_d;
      busy      <= (state_d == RUN);
      done      <= (state_d == DONE);
      illegal   <= (state_d == DONE) && illegal_d;
      alu_b     <= (state_d == RUN) ? WIDTH'(1) : '0;
      alu_alufn <= (state_d == RUN) ? {SHIFT_GRP, op_d} : ALUFN_PASS;
    end
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer with a small behavioural ALU on the alu_* ports.
`timescale 1ns/1ps
module tb_alu_shift_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SHW   = 5;
  localparam logic [5:0]  PASS  = 6'b000010;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src;
  logic [SHW-1:0]   shamt;
  logic             busy, done, illegal;
  logic [WIDTH-1:0] result, alu_a, alu_b, alu_otp;
  logic [5:0]       alu_alufn;
  logic             alu_zero;

  int total    = 0;
  int pass_cnt = 0;

  int          done_cyc, busy_cnt, run_cnt;
  logic [5:0]  fn_seen;
  logic [31:0] b_seen;
  logic        ill_at_done, busy_at_done;

  always #5 clk = ~clk;

  alu_shift_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src(src), .shamt(shamt),
    .busy(busy), .done(done), .illegal(illegal), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_alufn(alu_alufn),
    .alu_otp(alu_otp), .alu_zero(alu_zero)
  );

  // Reference ALU: shift group ops shift by one, anything else passes a through
  always_comb begin
    case (alu_alufn)
      6'b001000: alu_otp = alu_a << 1;
      6'b001001: alu_otp = WIDTH'($signed(alu_a) >>> 1);
      6'b001010: alu_otp = alu_a >> 1;
      default:   alu_otp = alu_a;
    endcase
    alu_zero = (alu_otp == '0);
  end

  // Launch one request (accepted at edge 0) and observe cycles 1..64 at the falling edge
  task automatic run_op(input logic [1:0] o, input logic [31:0] s, input logic [4:0] sh);
    @(negedge clk);
    op = o; src = s; shamt = sh; start = 1'b1;
    @(posedge clk);
    done_cyc = 0; busy_cnt = 0; run_cnt = 0;
    fn_seen = PASS; b_seen = '0; ill_at_done = 1'b0; busy_at_done = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (alu_alufn != PASS) begin
        run_cnt++;
        fn_seen = alu_alufn;
        b_seen  = alu_b;
      end
      if (done) begin
        done_cyc     = c;
        ill_at_done  = illegal;
        busy_at_done = busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = '0; src = '0; shamt = '0;
    repeat (2) @(negedge clk);
    total++; if ({busy, done, illegal} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, done, illegal}); else pass_cnt++;
    total++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result); else pass_cnt++;
    total++; if (alu_alufn !== PASS || alu_b !== 32'h0) $display("FAIL reset_alu: got alufn=%b b=%h expected 000010/0", alu_alufn, alu_b); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_sla();
    run_op(2'b00, 32'h0000_0001, 5'd4);
    total++; if (done_cyc !== 5) $display("FAIL sla_done_cycle: got %0d expected 5", done_cyc); else pass_cnt++;
    total++; if (result !== 32'h0000_0010) $display("FAIL sla_result: got %h expected 00000010", result); else pass_cnt++;
    total++; if (run_cnt !== 4 || fn_seen !== 6'b001000) $display("FAIL sla_alufn: got %0d cycles of %b expected 4 of 001000", run_cnt, fn_seen); else pass_cnt++;
    total++; if (b_seen !== 32'h1) $display("FAIL sla_alu_b: got %h expected 00000001", b_seen); else pass_cnt++;
    total++; if (ill_at_done !== 1'b0) $display("FAIL sla_illegal: got %b expected 0", ill_at_done); else pass_cnt++;
  endtask

  // start raised during the DONE cycle must be ignored
  task automatic test_start_in_done();
    start = 1'b1; op = 2'b10; src = 32'hAAAA_5555; shamt = 5'd0;
    @(negedge clk);
    start = 1'b0;
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL done_start_ignored: got done=%b busy=%b expected 0/0", done, busy); else pass_cnt++;
    total++; if (result !== 32'h0000_0010) $display("FAIL done_start_result: got %h expected 00000010", result); else pass_cnt++;
  endtask

  task automatic test_sra_max();
    run_op(2'b01, 32'h8000_0000, 5'd31);
    total++; if (done_cyc !== 32) $display("FAIL sra_done_cycle: got %0d expected 32", done_cyc); else pass_cnt++;
    total++; if (result !== 32'hFFFF_FFFF) $display("FAIL sra_result: got %h expected ffffffff", result); else pass_cnt++;
    total++; if (busy_cnt !== 31 || busy_at_done !== 1'b0) $display("FAIL sra_busy: got %0d busy cycles, busy@done=%b expected 31/0", busy_cnt, busy_at_done); else pass_cnt++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL sra_done_pulse: got %b expected 0", done); else pass_cnt++;
  endtask

  task automatic test_srl_zero_shamt();
    run_op(2'b10, 32'hDEAD_BEEF, 5'd0);
    total++; if (done_cyc !== 1) $display("FAIL srl0_done_cycle: got %0d expected 1", done_cyc); else pass_cnt++;
    total++; if (result !== 32'hDEAD_BEEF) $display("FAIL srl0_result: got %h expected deadbeef", result); else pass_cnt++;
    total++; if (run_cnt !== 0) $display("FAIL srl0_run_cycles: got %0d expected 0", run_cnt); else pass_cnt++;
  endtask

  task automatic test_illegal();
    run_op(2'b11, 32'h1234_5678, 5'd3);
    total++; if (done_cyc !== 1) $display("FAIL ill_done_cycle: got %0d expected 1", done_cyc); else pass_cnt++;
    total++; if (ill_at_done !== 1'b1) $display("FAIL ill_flag: got %b expected 1", ill_at_done); else pass_cnt++;
    total++; if (result !== 32'h1234_5678) $display("FAIL ill_result: got %h expected 12345678", result); else pass_cnt++;
    @(negedge clk);
    total++; if (illegal !== 1'b0) $display("FAIL ill_pulse: got %b expected 0", illegal); else pass_cnt++;
  endtask

  task automatic test_restart_and_reset();
    int dones;
    @(negedge clk);
    op = 2'b00; src = 32'h0000_0001; shamt = 5'd8; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;                 // cycle 1
    @(negedge clk);                               // cycle 2
    @(negedge clk); start = 1'b1; src = 32'h0000_00FF; shamt = 5'd1;  // cycle 3
    @(negedge clk); start = 1'b0;                 // cycle 4
    total++; if (busy !== 1'b1 || alu_a !== 32'h0000_0008) $display("FAIL restart_ignored: got busy=%b a=%h expected 1/00000008", busy, alu_a); else pass_cnt++;
    @(negedge clk); rst_n = 1'b0;                 // cycle 5
    #1;
    total++; if ({busy, done} !== 2'b00 || result !== 32'h0) $display("FAIL abort_state: got busy=%b done=%b result=%h expected 0/0/0", busy, done, result); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++; if (dones !== 0) $display("FAIL abort_no_done: got %0d done pulses expected 0", dones); else pass_cnt++;
  endtask

  task automatic test_zero_exit();
    run_op(2'b10, 32'h0000_0003, 5'd20);
`ifdef ZERO_EARLY_EXIT_EN
    total++; if (done_cyc !== 3) $display("FAIL zero_done_cycle: got %0d expected 3", done_cyc); else pass_cnt++;
`else
    total++; if (done_cyc !== 21) $display("FAIL zero_done_cycle: got %0d expected 21", done_cyc); else pass_cnt++;
`endif
    total++; if (result !== 32'h0) $display("FAIL zero_result: got %h expected 00000000", result); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sla();
    test_start_in_done();
    test_sra_max();
    test_srl_zero_shamt();
    test_illegal();
    test_restart_and_reset();
    test_zero_exit();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
